mux_nway_stream: RTL and testbench
==================================

Name: mux_nway_stream

Overview:
- Parametrised N-way, W-bit multiplexer with valid/ready handshakes on every input and on the output. Next generation of the 4-way 16-bit combinational mux.
- Adds a registered output stage, backpressure, and two selection modes: direct select (sel picks the input) and round-robin arbitration among valid inputs.
- Sits between multiple word producers (register file read ports, memory, I/O) and a single consumer in the datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, 2, select/index width. Must equal clog2(NUM_IN); the instantiating module sets it consistently with NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_data  input  NUM_IN*WIDTH  packed input words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- sel  input  SEL_W  channel index used in direct mode.
- mode  input  1  0 = direct select, 1 = round-robin.
- out_data  output  WIDTH  registered output word.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- One clock domain. Reset is synchronous and active-low; only rst_n low at a rising edge of clk resets the block.
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=NUM_IN-1, so the first round-robin grant search starts at channel 0.
- Reset mid-operation drops any held output word; nothing is replayed after reset.
- can_load = !out_valid || out_ready. The output register is empty or is being drained this cycle.
- Grant, computed combinationally every cycle:
  - Direct mode (mode=0): grant channel sel if sel < NUM_IN and in_valid[sel]=1. Otherwise there is no grant.
  - sel >= NUM_IN always produces no grant; in_ready stays all zeros.
  - Round-robin mode (mode=1): search channels ptr+1, ptr+2, … modulo NUM_IN. Grant the first one with in_valid=1. No grant if in_valid is all zeros.
- in_ready[i] = can_load && grant exists && (granted index == i). At most one in_ready bit is high; it is one-hot or zero.
- A transfer occurs on channel g when in_valid[g] && in_ready[g] at a rising edge. On that edge:
  - out_data ← word of channel g
  - out_src ← g
  - out_valid ← 1
  - ptr ← g. The pointer updates in both modes, so a switch to round-robin continues fairly.
- If there is no transfer and out_valid && out_ready: out_valid ← 0. out_data and out_src hold their last values.
- If there is no transfer and out_ready=0: the whole output register holds; out_data is stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input acceptance to out_valid. Throughput: 1 word/cycle when out_ready is held high. Drain and load in the same cycle are supported.
- mode or sel changes take effect on the next grant computation. They never alter a word already held in the output register.
- Producers may deassert in_valid without a transfer; the block imposes no stickiness on inputs.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_IN-1,0,… with no channel repeated before all others are served.
- ptr wraps from NUM_IN-1 to 0.

Test Plan (WIDTH=16, NUM_IN=4, SEL_W=2):
- Reset: hold rst_n=0 for 2 cycles with all inputs valid → out_valid=0, out_data=0x0000, out_src=0, in_ready=0000 during reset. First RR grant after release is channel 0.
- Direct mode: mode=0, sel=2, in_data ch2=0xBEEF, all valid, out_ready=1 → in_ready=0100. Next cycle out_data=0xBEEF, out_src=2, out_valid=1.
- Round-robin: mode=1, ch0..3 = 0x1111/0x2222/0x3333/0x4444, all valid, out_ready=1 → out_data sequence 0x1111, 0x2222, 0x3333, 0x4444, 0x1111 on consecutive cycles. Then drop ch1 valid → sequence continues 0,2,3,0.
- Backpressure: fill output with 0xA5A5, then out_ready=0 for 5 cycles → out_data stays 0xA5A5, out_valid=1, in_ready=0000. Raise out_ready → drain and a new load happen in the same cycle.
- Idle / no grant: mode=1 with all in_valid=0, or mode=0 with in_valid[sel]=0 → no transfer. out_valid falls to 0 after the current word drains; ptr unchanged.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 → next edge out_valid=0, ptr=3. After release, first RR grant is channel 0.

Source files
------------

// File: rtl/mux_nway_stream.sv
// N-way W-bit stream mux: direct-select or round-robin grant into one registered output word.
// Latency: 1 cycle from input acceptance to out_valid; 1 word/cycle sustained.
// Backpressure: out_ready=0 holds the output register and drops all in_ready; drain+load in one cycle.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_data/in_valid      NUM_IN packed words (channel i at [i*WIDTH +: WIDTH]) with per-channel valid
//   in_ready              per-channel ready, combinational, one-hot or zero
//   sel, mode             channel index for direct mode; mode 0 = direct, 1 = round-robin
//   out_data/out_src      registered word and the channel it came from
//   out_valid/out_ready   output handshake
module mux_nway_stream #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             can_load;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  assign can_load = !valid_q || out_ready;
  assign xfer     = can_load && gnt_vld;

  // Grant search. Direct mode matches sel against each real channel, so an
  // out-of-range sel simply never matches. Round-robin walks ptr+1, ptr+2, ...
  // and takes the first valid channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (!gnt_vld && in_valid[i] && ((int'(ptr_q) + k) % NUM_IN) == i) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready is masked while reset is held: any edge under reset discards the
  // word, so advertising acceptance would lie to the producer.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n && xfer && (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = gnt_data;
      src_d   = gnt_idx;
      valid_d = 1'b1;
      ptr_d   = gnt_idx;   // tracked in direct mode too, so a switch to RR stays fair
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SEL_W'(NUM_IN - 1);  // first RR search starts at channel 0
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nway_stream.sv
// Bench for mux_nway_stream: directed scenarios plus randomized traffic, with a
// scoreboard queue filled at acceptance and drained by an output monitor.
module tb_mux_nway_stream;
  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  always #5 clk = ~clk;

  mux_nway_stream #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [SEL_W+WIDTH-1:0] sb_q[$];

  // Reference state: last granted channel, whether a word is held, and that word.
  int               m_ptr   = NUM_IN - 1;
  bit               m_full  = 1'b0;
  bit               m_known = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [SEL_W-1:0] m_src   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say wins, or -1 for none.
  function automatic int ref_grant(input bit md, input int s, input logic [3:0] v, input int p);
    if (!md) begin
      if (s < NUM_IN && v[s]) return s;
      return -1;
    end
    for (int k = 1; k <= NUM_IN; k++) begin
      int c;
      c = (p + k) % NUM_IN;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check combinational ready and held output against
  // the model, record any accepted word, advance the model across the edge.
  task automatic cycle(input bit rst, input bit md, input logic [1:0] s,
                       input logic [3:0] v, input logic [63:0] d, input bit ordy);
    int g;
    logic [3:0] exp_rdy;
    rst_n = rst; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = -1;
    if (rst && (!m_full || ordy)) g = ref_grant(md, int'(s), v, m_ptr);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
    if (m_known) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
      if (m_full) begin
        chk("out_data_held", {16'b0, out_data}, {16'b0, m_data});
        chk("out_src_held", {30'b0, out_src}, {30'b0, m_src});
      end
    end
    if (!rst) begin
      sb_q.delete();
      m_full  = 1'b0;
      m_ptr   = NUM_IN - 1;
      m_known = 1'b1;
      m_data  = '0;
      m_src   = '0;
    end else if (g >= 0) begin
      m_data = d[g*WIDTH +: WIDTH];
      m_src  = 2'(g);
      m_full = 1'b1;
      m_ptr  = g;
      sb_q.push_back({m_src, m_data});
    end else if (ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: a word counts as delivered when valid and ready meet.
  initial begin
    logic [SEL_W+WIDTH-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got src=%0d data=0x%0h, expected no word", out_src, out_data);
        end else begin
          exp_w = sb_q.pop_front();
          chk("sb_word", {14'b0, out_src, out_data}, {14'b0, exp_w});
        end
      end
    end
  end

  localparam logic [63:0] D_RR   = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D_BEEF = 64'h0000_BEEF_0000_0000;
  localparam logic [63:0] D_A5   = 64'h0000_0000_0000_A5A5;

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset with every channel valid.
    repeat (2) cycle(1'b0, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", {16'b0, out_data}, 32'h0);
    chk("reset_out_src", {30'b0, out_src}, 32'd0);

    // First RR grant after reset is channel 0.
    cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    chk("first_rr_src", {30'b0, out_src}, 32'd0);

    // Direct select of channel 2.
    cycle(1'b1, 1'b0, 2'd2, 4'hF, D_BEEF, 1'b1);
    chk("direct_data", {16'b0, out_data}, 32'hBEEF);
    chk("direct_src", {30'b0, out_src}, 32'd2);

    // Park the pointer on 3, then round-robin over all, then with ch1 absent.
    cycle(1'b1, 1'b0, 2'd3, 4'hF, D_RR, 1'b1);
    repeat (5) cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    repeat (4) cycle(1'b1, 1'b1, 2'd0, 4'b1101, D_RR, 1'b1);

    // Backpressure: hold 0xA5A5 for 5 cycles, then drain and load together.
    cycle(1'b1, 1'b0, 2'd0, 4'hF, D_A5, 1'b1);
    repeat (5) begin
      cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b0);
      chk("bp_hold_data", {16'b0, out_data}, 32'hA5A5);
    end
    cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    chk("bp_reload_src", {30'b0, out_src}, 32'd1);

    // Idle: nothing valid in RR, then direct on an invalid channel.
    repeat (2) cycle(1'b1, 1'b1, 2'd0, 4'b0000, D_RR, 1'b1);
    cycle(1'b1, 1'b0, 2'd1, 4'b1101, D_RR, 1'b1);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    chk("idle_ptr_kept", {30'b0, out_src}, 32'd2);

    // Reset while a word is held under backpressure.
    cycle(1'b1, 1'b0, 2'd3, 4'hF, D_RR, 1'b1);
    cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b0);
    cycle(1'b0, 1'b1, 2'd0, 4'hF, D_RR, 1'b0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    cycle(1'b1, 1'b1, 2'd0, 4'hF, D_RR, 1'b1);
    chk("midrst_first_rr", {30'b0, out_src}, 32'd0);

    // Randomized traffic with occasional resets and backpressure.
    repeat (600) begin
      cycle(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    end

    // Drain whatever is left.
    repeat (3) cycle(1'b1, 1'b0, 2'd0, 4'b0000, 64'h0, 1'b1);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
